pixel_stream_checker: RTL and testbench

Synthesizable on-chip checker for the convolution output path. It takes the 12-bit pixel stream from the convolution datapath (stream A) and a golden pixel stream replayed from memory (stream B). It buffers both, compares them pixel by pixel within a tolerance, and reports:
- the number of compared pixels,
- the number of mismatches,
- the first failing pixel's index and values,
- a pass/fail verdict once a full frame has been consumed.

It replaces file-based offline comparison for hardware runs.

---
 rtl/pixel_cmp_pkg.sv | 21 ++
 rtl/sync_fifo.sv | 52 +++++
 rtl/pixel_stream_checker.sv | 125 ++++++++++++
 tb/tb_pixel_stream_checker.sv | 399 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pixel_cmp_pkg.sv
// rtl/pixel_cmp_pkg.sv - shared state encoding and compare helper for the pixel stream checker
package pixel_cmp_pkg;

    localparam int PIX_W_DEFAULT = 12;
    localparam int DIFF_MAX_W    = 31;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_RUN  = 2'd1;
    localparam state_t ST_DONE = 2'd2;

    // Operands are zero-extended pixels; the signed difference carries one extra bit so it never wraps.
    function automatic logic [DIFF_MAX_W-1:0] abs_diff(input logic [DIFF_MAX_W-1:0] a,
                                                       input logic [DIFF_MAX_W-1:0] b);
        logic signed [DIFF_MAX_W:0] d;
        d = $signed({1'b0, a}) - $signed({1'b0, b});
        abs_diff = d[DIFF_MAX_W] ? DIFF_MAX_W'(-d) : d[DIFF_MAX_W-1:0];
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with first-word-fall-through output and synchronous clear
module sync_fifo #(
    parameter int WIDTH = 12,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Pointers carry a wrap bit so full and empty are distinguishable with equal indices.
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty   = (wr_ptr == rd_ptr);
    assign dout    = mem[rd_ptr[AW-1:0]];
    assign do_push = push && !full && !clr;
    assign do_pop  = pop && !empty && !clr;

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/pixel_stream_checker.sv
// rtl/pixel_stream_checker.sv - compares a DUT pixel stream against a golden stream within a tolerance
module pixel_stream_checker
    import pixel_cmp_pkg::*;
#(
    parameter int PIX_W      = PIX_W_DEFAULT,
    parameter int NUM_PIXELS = 65536,
    parameter int CNT_W      = 17,
    parameter int FIFO_DEPTH = 4,
    parameter int TOL        = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [PIX_W-1:0] a_data,
    input  logic             a_valid,
    output logic             a_ready,
    input  logic [PIX_W-1:0] b_data,
    input  logic             b_valid,
    output logic             b_ready,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] cmp_cnt,
    output logic [CNT_W-1:0] mismatch_cnt,
    output logic [CNT_W-1:0] first_err_idx,
    output logic [PIX_W-1:0] first_err_a,
    output logic [PIX_W-1:0] first_err_b,
    output logic             err_seen
);

    if ((64'd1 << CNT_W) <= 64'(NUM_PIXELS)) begin : g_bad_cnt_w
        $error("CNT_W too narrow to count NUM_PIXELS");
    end
    if (PIX_W > DIFF_MAX_W) begin : g_bad_pix_w
        $error("PIX_W wider than the compare helper supports");
    end

    state_t           state;
    logic             a_full;
    logic             a_empty;
    logic             b_full;
    logic             b_empty;
    logic [PIX_W-1:0] a_head;
    logic [PIX_W-1:0] b_head;
    logic             a_push;
    logic             b_push;
    logic             cmp_fire;
    logic             is_mismatch;
    logic [CNT_W-1:0] cmp_next;

    assign a_ready = (state == ST_RUN) && !a_full;
    assign b_ready = (state == ST_RUN) && !b_full;
    assign a_push  = a_valid && a_ready;
    assign b_push  = b_valid && b_ready;

    // A restart clears both FIFOs on this edge, so nothing may be popped in that cycle.
    assign cmp_fire    = (state == ST_RUN) && !start && !a_empty && !b_empty;
    assign is_mismatch = abs_diff(DIFF_MAX_W'(a_head), DIFF_MAX_W'(b_head)) > DIFF_MAX_W'(TOL);
    assign cmp_next    = cmp_cnt + 1'b1;

    assign busy = (state == ST_RUN);
    assign done = (state == ST_DONE);
    assign pass = done && (mismatch_cnt == '0);

    sync_fifo #(.WIDTH(PIX_W), .DEPTH(FIFO_DEPTH)) u_fifo_a (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (start),
        .push  (a_push),
        .pop   (cmp_fire),
        .din   (a_data),
        .dout  (a_head),
        .full  (a_full),
        .empty (a_empty)
    );

    sync_fifo #(.WIDTH(PIX_W), .DEPTH(FIFO_DEPTH)) u_fifo_b (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (start),
        .push  (b_push),
        .pop   (cmp_fire),
        .din   (b_data),
        .dout  (b_head),
        .full  (b_full),
        .empty (b_empty)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            cmp_cnt       <= '0;
            mismatch_cnt  <= '0;
            first_err_idx <= '0;
            first_err_a   <= '0;
            first_err_b   <= '0;
            err_seen      <= 1'b0;
        end else if (start) begin
            state         <= ST_RUN;
            cmp_cnt       <= '0;
            mismatch_cnt  <= '0;
            first_err_idx <= '0;
            first_err_a   <= '0;
            first_err_b   <= '0;
            err_seen      <= 1'b0;
        end else if (cmp_fire) begin
            cmp_cnt <= cmp_next;
            if (is_mismatch) begin
                if (mismatch_cnt != '1) begin
                    mismatch_cnt <= mismatch_cnt + 1'b1;
                end
                if (!err_seen) begin
                    first_err_idx <= cmp_cnt;
                    first_err_a   <= a_head;
                    first_err_b   <= b_head;
                    err_seen      <= 1'b1;
                end
            end
            if (cmp_next == CNT_W'(NUM_PIXELS)) begin
                state <= ST_DONE;
            end
        end
    end

endmodule

// File: tb/tb_pixel_stream_checker.sv
// tb/tb_pixel_stream_checker.sv - self-checking bench for pixel_stream_checker
module tb_pixel_stream_checker;

    localparam int N   = 16;
    localparam int TOL = 2;
    localparam int CW  = 5;

    typedef struct {
        int a;
        int b;
        bit mm;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n, start;
    logic [11:0]   a_data, b_data;
    logic          a_valid, a_ready, b_valid, b_ready;
    logic          busy, done, pass, err_seen;
    logic [CW-1:0] cmp_cnt, mismatch_cnt, first_err_idx;
    logic [11:0]   first_err_a, first_err_b;

    logic          s_start;
    logic [11:0]   s_a_data, s_b_data;
    logic          s_a_valid, s_a_ready, s_b_valid, s_b_ready;
    logic          s_busy, s_done, s_pass, s_err_seen;
    logic [2:0]    s_cmp_cnt, s_mismatch_cnt, s_first_err_idx;
    logic [11:0]   s_first_err_a, s_first_err_b;

    int   n_vec = 0;
    int   n_bad = 0;
    int   a_q[$];
    int   b_q[$];
    int   fa[N];
    int   fb[N];
    bit   exp_mm[N];
    vec_t tol_tab[N];
    bit   a_en = 1'b1, b_en = 1'b1, flush = 1'b0;
    int   a_duty = 100, b_duty = 100;
    int   a_acc_cnt = 0;
    int   e_mm, e_idx, e_a, e_b;
    bit   e_seen;

    pixel_stream_checker #(
        .PIX_W(12), .NUM_PIXELS(N), .CNT_W(CW), .FIFO_DEPTH(4), .TOL(TOL)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .a_data(a_data), .a_valid(a_valid), .a_ready(a_ready),
        .b_data(b_data), .b_valid(b_valid), .b_ready(b_ready),
        .busy(busy), .done(done), .pass(pass),
        .cmp_cnt(cmp_cnt), .mismatch_cnt(mismatch_cnt),
        .first_err_idx(first_err_idx), .first_err_a(first_err_a), .first_err_b(first_err_b),
        .err_seen(err_seen)
    );

    pixel_stream_checker #(
        .PIX_W(12), .NUM_PIXELS(7), .CNT_W(3), .FIFO_DEPTH(2), .TOL(0)
    ) dut_sat (
        .clk(clk), .rst_n(rst_n), .start(s_start),
        .a_data(s_a_data), .a_valid(s_a_valid), .a_ready(s_a_ready),
        .b_data(s_b_data), .b_valid(s_b_valid), .b_ready(s_b_ready),
        .busy(s_busy), .done(s_done), .pass(s_pass),
        .cmp_cnt(s_cmp_cnt), .mismatch_cnt(s_mismatch_cnt),
        .first_err_idx(s_first_err_idx), .first_err_a(s_first_err_a), .first_err_b(s_first_err_b),
        .err_seen(s_err_seen)
    );

    function automatic void check(string name, int act, int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endfunction

    // Upstream drivers: hold valid until accepted, then optionally offer the next beat.
    initial begin : drv_a
        logic acc;
        a_valid = 1'b0;
        a_data  = '0;
        forever begin
            @(negedge clk);
            acc = a_valid && a_ready;
            @(posedge clk);
            #1;
            if (acc) begin
                void'(a_q.pop_front());
                a_valid = 1'b0;
                a_acc_cnt++;
            end
            if (flush) begin
                a_valid = 1'b0;
                a_q.delete();
            end else if (!a_valid && a_en && a_q.size() > 0 && $urandom_range(0, 99) < a_duty) begin
                a_valid = 1'b1;
                a_data  = 12'(a_q[0]);
            end
        end
    end

    initial begin : drv_b
        logic acc;
        b_valid = 1'b0;
        b_data  = '0;
        forever begin
            @(negedge clk);
            acc = b_valid && b_ready;
            @(posedge clk);
            #1;
            if (acc) begin
                void'(b_q.pop_front());
                b_valid = 1'b0;
            end
            if (flush) begin
                b_valid = 1'b0;
                b_q.delete();
            end else if (!b_valid && b_en && b_q.size() > 0 && $urandom_range(0, 99) < b_duty) begin
                b_valid = 1'b1;
                b_data  = 12'(b_q[0]);
            end
        end
    end

    // Each compare must raise mismatch_cnt by exactly the expected verdict for that pixel index.
    initial begin : monitor
        int prev_cmp;
        int prev_mm;
        prev_cmp = 0;
        prev_mm  = 0;
        forever begin
            @(posedge clk);
            #2;
            if (rst_n) begin
                if (int'(cmp_cnt) == prev_cmp + 1) begin
                    if (prev_cmp < N)
                        check($sformatf("mm_step[%0d]", prev_cmp), int'(mismatch_cnt) - prev_mm,
                              int'(exp_mm[prev_cmp]));
                end else if (int'(cmp_cnt) != prev_cmp && cmp_cnt != '0) begin
                    check("cmp_step", int'(cmp_cnt), prev_cmp + 1);
                end
            end
            prev_cmp = int'(cmp_cnt);
            prev_mm  = int'(mismatch_cnt);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_frame();
        e_mm = 0; e_seen = 1'b0; e_idx = 0; e_a = 0; e_b = 0;
        for (int i = 0; i < N; i++) begin
            int d;
            d = fa[i] - fb[i];
            if (d < 0) d = -d;
            exp_mm[i] = (d > TOL);
            a_q.push_back(fa[i]);
            b_q.push_back(fb[i]);
            if (exp_mm[i]) begin
                if (!e_seen) begin
                    e_seen = 1'b1; e_idx = i; e_a = fa[i]; e_b = fb[i];
                end
                e_mm++;
            end
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (!done && lat < 500) begin
            step();
            lat++;
        end
        if (!done) check("done_timeout", 0, 1);
    endtask

    task automatic wait_cmp(input int k);
        int c;
        c = 0;
        while (int'(cmp_cnt) < k && c < 300) begin
            step();
            c++;
        end
        if (int'(cmp_cnt) < k) check("cmp_timeout", int'(cmp_cnt), k);
    endtask

    task automatic check_zero(string tag);
        check({tag, ".busy"}, busy, 0);
        check({tag, ".done"}, done, 0);
        check({tag, ".pass"}, pass, 0);
        check({tag, ".a_ready"}, a_ready, 0);
        check({tag, ".b_ready"}, b_ready, 0);
        check({tag, ".cmp_cnt"}, int'(cmp_cnt), 0);
        check({tag, ".mismatch_cnt"}, int'(mismatch_cnt), 0);
        check({tag, ".first_err_idx"}, int'(first_err_idx), 0);
        check({tag, ".first_err_a"}, int'(first_err_a), 0);
        check({tag, ".first_err_b"}, int'(first_err_b), 0);
        check({tag, ".err_seen"}, err_seen, 0);
    endtask

    task automatic check_final(string tag);
        check({tag, ".done"}, done, 1);
        check({tag, ".busy"}, busy, 0);
        check({tag, ".a_ready"}, a_ready, 0);
        check({tag, ".cmp_cnt"}, int'(cmp_cnt), N);
        check({tag, ".mismatch_cnt"}, int'(mismatch_cnt), e_mm);
        check({tag, ".err_seen"}, err_seen, int'(e_seen));
        check({tag, ".pass"}, pass, int'(e_mm == 0));
        check({tag, ".first_err_idx"}, int'(first_err_idx), e_idx);
        check({tag, ".first_err_a"}, int'(first_err_a), e_a);
        check({tag, ".first_err_b"}, int'(first_err_b), e_b);
    endtask

    task automatic run_frame(string tag);
        int lat;
        load_frame();
        step();
        pulse_start();
        wait_done(lat);
        check_final(tag);
    endtask

    initial begin : main
        int lat, tot_mm, tot_cmp, k, cyc;
        int err_pos[3];
        logic acc;

        rst_n = 1'b0; start = 1'b0;
        s_start = 1'b0; s_a_valid = 1'b0; s_b_valid = 1'b0; s_a_data = '0; s_b_data = '0;

        for (int i = 0; i < N; i++) tol_tab[i] = '{i * 200, i * 200, 1'b0};
        tol_tab[3]  = '{16, 18, 1'b0};
        tol_tab[5]  = '{256, 259, 1'b1};
        tol_tab[9]  = '{4095, 0, 1'b1};
        tol_tab[12] = '{2050, 2048, 1'b0};

        repeat (3) step();
        check_zero("reset");
        rst_n = 1'b1;
        repeat (2) step();
        check("idle.a_ready", a_ready, 0);
        check("idle.busy", busy, 0);

        // Matching frame at full rate
        for (int i = 0; i < N; i++) begin fa[i] = i; fb[i] = i; end
        load_frame();
        step();
        pulse_start();
        wait_done(lat);
        check("match.done_latency", lat + 1, 18);
        check_final("match");

        // Tolerance table, verdicts per pixel taken from the table
        for (int i = 0; i < N; i++) begin fa[i] = tol_tab[i].a; fb[i] = tol_tab[i].b; end
        load_frame();
        for (int i = 0; i < N; i++) exp_mm[i] = tol_tab[i].mm;
        step();
        pulse_start();
        wait_done(lat);
        check_final("tol");
        check("tol.mismatch_const", int'(mismatch_cnt), 2);
        check("tol.idx_const", int'(first_err_idx), 5);
        check("tol.a_const", int'(first_err_a), 'h100);
        check("tol.b_const", int'(first_err_b), 'h103);

        // Skew: B held off while A fills its FIFO
        for (int i = 0; i < N; i++) begin fa[i] = $urandom_range(0, 4095); fb[i] = fa[i]; end
        load_frame();
        b_en = 1'b0;
        step();
        a_acc_cnt = 0;
        pulse_start();
        repeat (20) step();
        check("skew.a_accepted", a_acc_cnt, 4);
        check("skew.a_ready", a_ready, 0);
        check("skew.b_ready", b_ready, 1);
        check("skew.cmp_cnt", int'(cmp_cnt), 0);
        b_en = 1'b1;
        wait_done(lat);
        check_final("skew");

        // Random valid toggling, 64 pixels over four frames with three injected errors
        a_duty = 50; b_duty = 50;
        err_pos[0] = $urandom_range(0, 20);
        err_pos[1] = $urandom_range(21, 42);
        err_pos[2] = $urandom_range(43, 63);
        tot_mm = 0; tot_cmp = 0;
        for (int f = 0; f < 4; f++) begin
            for (int i = 0; i < N; i++) begin
                int off;
                fa[i] = $urandom_range(0, 4095);
                off   = int'($urandom_range(0, 4)) - 2;
                fb[i] = (fa[i] + off < 0 || fa[i] + off > 4095) ? fa[i] : fa[i] + off;
                if (f * N + i == err_pos[0] || f * N + i == err_pos[1] || f * N + i == err_pos[2])
                    fb[i] = fa[i] ^ 'h800;
            end
            run_frame($sformatf("rand%0d", f));
            tot_mm  += int'(mismatch_cnt);
            tot_cmp += int'(cmp_cnt);
        end
        check("rand.total_mismatch", tot_mm, 3);
        check("rand.total_cmp", tot_cmp, 64);
        a_duty = 100; b_duty = 100;

        // Restart mid-frame with stale A beats left in its FIFO
        for (int i = 0; i < N; i++) begin fa[i] = i; fb[i] = i; end
        fb[2] = fa[2] ^ 'h800;
        load_frame();
        step();
        pulse_start();
        wait_cmp(7);
        b_en = 1'b0;
        repeat (3) step();
        flush = 1'b1;
        repeat (2) step();
        flush = 1'b0;
        check("restart.err_before", err_seen, 1);
        pulse_start();
        check("restart.cmp_cnt", int'(cmp_cnt), 0);
        check("restart.mismatch_cnt", int'(mismatch_cnt), 0);
        check("restart.err_seen", err_seen, 0);
        check("restart.busy", busy, 1);
        b_en = 1'b1;
        for (int i = 0; i < N; i++) begin fa[i] = i + 100; fb[i] = i + 100; end
        fb[11] = fa[11] ^ 'h800;
        load_frame();
        wait_done(lat);
        check_final("restart");

        // Reset mid-frame
        for (int i = 0; i < N; i++) begin fa[i] = i * 3; fb[i] = i * 3; end
        fb[1] = fa[1] ^ 'h800;
        load_frame();
        step();
        pulse_start();
        wait_cmp(4);
        check("midrst.err_before", err_seen, 1);
        rst_n = 1'b0;
        flush = 1'b1;
        step();
        check_zero("midrst");
        rst_n = 1'b1;
        flush = 1'b0;
        repeat (3) step();
        check("midrst.idle_a_ready", a_ready, 0);
        check("midrst.idle_b_ready", b_ready, 0);
        check("midrst.idle_busy", busy, 0);
        for (int i = 0; i < N; i++) begin fa[i] = $urandom_range(0, 4095); fb[i] = fa[i]; end
        fb[0] = fa[0] ^ 'h800;
        run_frame("recover");

        // Narrow counters: every one of 7 pixels differs by 1
        s_start = 1'b1;
        step();
        s_start = 1'b0;
        k = 0; cyc = 0;
        s_a_valid = 1'b1; s_b_valid = 1'b1; s_a_data = 12'd0; s_b_data = 12'd1;
        while (!s_done && cyc < 200) begin
            @(negedge clk);
            acc = s_a_ready && s_b_ready;
            step();
            cyc++;
            if (acc) begin
                k++;
                s_a_data = 12'(k);
                s_b_data = 12'(k ^ 1);
            end
        end
        s_a_valid = 1'b0; s_b_valid = 1'b0;
        check("sat.done", s_done, 1);
        check("sat.cmp_cnt", int'(s_cmp_cnt), 7);
        check("sat.mismatch_cnt", int'(s_mismatch_cnt), 7);
        check("sat.pass", s_pass, 0);
        check("sat.err_seen", s_err_seen, 1);
        check("sat.first_err_idx", int'(s_first_err_idx), 0);
        check("sat.first_err_a", int'(s_first_err_a), 0);
        check("sat.first_err_b", int'(s_first_err_b), 1);
        check("sat.busy", s_busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
